// File: rtl/axi_lite_read_requester_pkg.sv
// Shared constants for the AXI-Lite read requester: response codes and FSM encoding.
// Imported by the requester top and its watchdog.
package axi_lite_read_requester_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Anything other than OKAY is logged as a failed read.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_read_requester_watchdog.sv
// Transaction watchdog: counts busy cycles and flags the last allowed cycle.
// A TIMEOUT_CYCLES of zero disables expiry entirely.
module axi_lite_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int         CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit         ENABLED = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == LAST);

   // Count parks at the last value so the compare stays true if a late
   // address handshake carries the transaction into the data phase.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_at_last) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expire = ENABLED && i_enable && w_at_last;

endmodule

// File: rtl/axi_lite_read_requester.sv
// Single-outstanding AXI-Lite read master: client command in, AR/R out to the
// register-file slave, data plus status back to the client, with watchdog abort.
//
// state | meaning
// IDLE  | waiting for a client command, cmd_ready high
// ADDR  | AR valid driven, waiting for read_address_ready
// DATA  | R ready driven, waiting for read_data_valid
// RESP  | response held for the client until rsp_ready
module axi_lite_read_requester
   import axi_lite_read_requester_pkg::*;
#(
   parameter int ADDRESS_SIZE   = 32,
   parameter int DATA_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ERR_CNT_SIZE   = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDRESS_SIZE-1:0] cmd_address,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   output logic [DATA_SIZE-1:0]    rsp_data,
   output logic [1:0]              rsp_response,
   output logic                    rsp_timeout,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ADDRESS_SIZE-1:0] read_address,
   output logic                    read_address_valid,
   input  logic                    read_address_ready,
   input  logic [DATA_SIZE-1:0]    read_data,
   input  logic                    read_data_valid,
   output logic                    read_data_ready,
   input  logic [1:0]              read_data_response,
   output logic [ERR_CNT_SIZE-1:0] error_count
);

   logic [1:0]              r_state;
   logic                    r_cmd_ready;
   logic [ADDRESS_SIZE-1:0] r_read_address;
   logic                    r_arvalid;
   logic                    r_rready;
   logic [DATA_SIZE-1:0]    r_rsp_data;
   logic [1:0]              r_rsp_response;
   logic                    r_rsp_timeout;
   logic                    r_rsp_valid;
   logic [ERR_CNT_SIZE-1:0] r_err_cnt;

   logic w_cmd_hs;
   logic w_ar_hs;
   logic w_r_hs;
   logic w_rsp_hs;
   logic w_wd_clear;
   logic w_wd_enable;
   logic w_wd_expire;
   logic w_abort;
   logic w_err_event;

   assign w_cmd_hs = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
   assign w_ar_hs  = (r_state == ST_ADDR) && r_arvalid && read_address_ready;
   assign w_r_hs   = (r_state == ST_DATA) && r_rready && read_data_valid;
   assign w_rsp_hs = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;

   assign w_wd_clear  = (r_state == ST_IDLE);
   assign w_wd_enable = (r_state == ST_ADDR) || (r_state == ST_DATA);

   axi_lite_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (aclk),
      .i_reset  (areset),
      .i_clear  (w_wd_clear),
      .i_enable (w_wd_enable),
      .o_expire (w_wd_expire)
   );

   // A handshake in the expiry cycle takes priority over the abort.
   assign w_abort = w_wd_expire &&
                    (((r_state == ST_ADDR) && !w_ar_hs) ||
                     ((r_state == ST_DATA) && !w_r_hs));

   assign w_err_event = w_abort || (w_r_hs && resp_is_error(read_data_response));

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state        <= ST_IDLE;
         r_cmd_ready    <= 1'b1;
         r_read_address <= '0;
         r_arvalid      <= 1'b0;
         r_rready       <= 1'b0;
         r_rsp_data     <= '0;
         r_rsp_response <= RESP_OKAY;
         r_rsp_timeout  <= 1'b0;
         r_rsp_valid    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_hs) begin
                  r_read_address <= cmd_address;
                  r_cmd_ready    <= 1'b0;
                  r_arvalid      <= 1'b1;
                  r_state        <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_DATA;
               end else if (w_abort) begin
                  r_arvalid      <= 1'b0;
                  r_rsp_data     <= '0;
                  r_rsp_response <= RESP_DECERR;
                  r_rsp_timeout  <= 1'b1;
                  r_rsp_valid    <= 1'b1;
                  r_state        <= ST_RESP;
               end
            end
            ST_DATA: begin
               if (w_r_hs) begin
                  r_rsp_data     <= read_data;
                  r_rsp_response <= read_data_response;
                  r_rsp_timeout  <= 1'b0;
                  r_rready       <= 1'b0;
                  r_rsp_valid    <= 1'b1;
                  r_state        <= ST_RESP;
               end else if (w_abort) begin
                  r_rready       <= 1'b0;
                  r_rsp_data     <= '0;
                  r_rsp_response <= RESP_DECERR;
                  r_rsp_timeout  <= 1'b1;
                  r_rsp_valid    <= 1'b1;
                  r_state        <= ST_RESP;
               end
            end
            default: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_err_cnt <= '0;
      end else if (w_err_event && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_SIZE'(1);
      end
   end

   assign cmd_ready          = r_cmd_ready;
   assign read_address       = r_read_address;
   assign read_address_valid = r_arvalid;
   assign read_data_ready    = r_rready;
   assign rsp_data           = r_rsp_data;
   assign rsp_response       = r_rsp_response;
   assign rsp_timeout        = r_rsp_timeout;
   assign rsp_valid          = r_rsp_valid;
   assign error_count        = r_err_cnt;

endmodule
